// File: rtl/fbuf_pixel_fetch_pkg.sv
// Shared video definitions for the framebuffer pixel fetch path: widths,
// the palette entry type, the strobe bundle carried down the pipeline, and the reset ramp.
package fbuf_pixel_fetch_pkg;

    localparam int RGB_W       = 24;
    localparam int PAL_ENTRIES = 16;
    localparam int PAL_IDX_W   = 4;

    typedef logic [RGB_W-1:0]     rgb_t;
    typedef logic [PAL_IDX_W-1:0] pal_idx_t;

    // Everything that must stay aligned with a pixel while its BRAM read is in flight.
    typedef struct packed {
        logic     hsync;
        logic     vsync;
        logic     vde;
        logic     test_pattern;
        pal_idx_t nibble;
    } strobe_t;

    // Reset palette: entry i is grey level i*17, giving 00..FF across the 16 entries.
    function automatic rgb_t grey_ramp(input pal_idx_t idx);
        logic [7:0] level;
        level = 8'(idx) * 8'd17;
        return {level, level, level};
    endfunction

endpackage

// File: rtl/fbuf_palette.sv
// Double-buffered 16x24 palette: writes go to a shadow bank, which is copied
// into the active bank on a rising edge of eof so a frame never sees a partial update.
module fbuf_palette
    import fbuf_pixel_fetch_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     wr_en,
    input  pal_idx_t wr_addr,
    input  rgb_t     wr_data,
    input  logic     eof,
    input  pal_idx_t rd_idx,
    output rgb_t     rd_data,
    output logic     pending
);

    rgb_t shadow [PAL_ENTRIES];
    rgb_t active [PAL_ENTRIES];
    logic eof_q;
    logic commit;

    assign commit = eof & ~eof_q & pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eof_q <= 1'b0;
        end else begin
            eof_q <= eof;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PAL_ENTRIES; i++) begin
                shadow[i] <= grey_ramp(PAL_IDX_W'(i));
            end
        end else if (wr_en) begin
            shadow[wr_addr] <= wr_data;
        end
    end

    // A write coinciding with a commit lands only in shadow; active takes the pre-write copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PAL_ENTRIES; i++) begin
                active[i] <= grey_ramp(PAL_IDX_W'(i));
            end
        end else if (commit) begin
            for (int i = 0; i < PAL_ENTRIES; i++) begin
                active[i] <= shadow[i];
            end
        end
    end

    // The write keeps pending set so a same-cycle write is applied at the next frame's commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (wr_en) begin
            pending <= 1'b1;
        end else if (commit) begin
            pending <= 1'b0;
        end
    end

    assign rd_data = active[rd_idx];

endmodule

// File: rtl/fbuf_pixel_fetch.sv
// Framebuffer pixel fetch: registers the BRAM read request, carries the timing strobes
// across the BRAM latency, and maps each stored index through the palette to RGB888.
module fbuf_pixel_fetch
    import fbuf_pixel_fetch_pkg::*;
#(
    parameter int BRAM_LATENCY = 2,
    parameter int ADDR_W       = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic                 vde_in,
    input  logic                 eof_in,
    input  logic [ADDR_W-1:0]    fbuf_address_in,
    input  logic                 test_pattern,
    output logic                 bram_en,
    output logic [ADDR_W-1:0]    bram_addr,
    input  logic [7:0]           bram_data,
    input  logic                 pal_wr_en,
    input  logic [PAL_IDX_W-1:0] pal_wr_addr,
    input  logic [RGB_W-1:0]     pal_wr_data,
    output logic                 pal_pending,
    output logic [RGB_W-1:0]     rgb,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 vde
);

    strobe_t  stage_a;
    strobe_t  dline [BRAM_LATENCY];
    strobe_t  stage_b;
    pal_idx_t pal_idx;
    rgb_t     pal_rgb;
    logic     unused_bram_low;

    assign unused_bram_low = ^bram_data[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bram_addr <= '0;
            bram_en   <= 1'b0;
            stage_a   <= '0;
        end else begin
            bram_addr            <= fbuf_address_in;
            bram_en              <= vde_in & ~test_pattern;
            stage_a.hsync        <= hsync_in;
            stage_a.vsync        <= vsync_in;
            stage_a.vde          <= vde_in;
            stage_a.test_pattern <= test_pattern;
            stage_a.nibble       <= fbuf_address_in[3:0];
        end
    end

    // Delay line matched to the BRAM read latency so strobes meet their data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BRAM_LATENCY; i++) begin
                dline[i] <= '0;
            end
        end else begin
            dline[0] <= stage_a;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                dline[i] <= dline[i-1];
            end
        end
    end

    assign stage_b = dline[BRAM_LATENCY-1];
    assign pal_idx = stage_b.test_pattern ? stage_b.nibble : bram_data[7:4];

    fbuf_palette u_palette (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pal_wr_en),
        .wr_addr (pal_wr_addr),
        .wr_data (pal_wr_data),
        .eof     (eof_in),
        .rd_idx  (pal_idx),
        .rd_data (pal_rgb),
        .pending (pal_pending)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb   <= '0;
            hsync <= 1'b0;
            vsync <= 1'b0;
            vde   <= 1'b0;
        end else begin
            rgb   <= stage_b.vde ? pal_rgb : '0;
            hsync <= stage_b.hsync;
            vsync <= stage_b.vsync;
            vde   <= stage_b.vde;
        end
    end

endmodule

// File: tb/tb_fbuf_pixel_fetch.sv
// Bench for fbuf_pixel_fetch: two instances (BRAM latency 2 and 3) share one stimulus
// stream; expected pixels are queued when driven and compared when their due cycle arrives.
module tb_fbuf_pixel_fetch;
    import fbuf_pixel_fetch_pkg::*;

    localparam int ADDR_W = 17;
    localparam int LAT2   = 4;
    localparam int LAT3   = 5;

    typedef struct packed {
        logic              h;
        logic              v;
        logic              de;
        logic              eof;
        logic              tp;
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [3:0]        wa;
        logic [23:0]       wd;
    } stim_t;

    typedef struct {
        int          due;
        logic [26:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic hsync_in = 1'b0, vsync_in = 1'b0, vde_in = 1'b0, eof_in = 1'b0, test_pattern = 1'b0;
    logic [ADDR_W-1:0] fbuf_address_in = '0;
    logic pal_wr_en = 1'b0;
    logic [3:0] pal_wr_addr = '0;
    logic [23:0] pal_wr_data = '0;

    logic bram_en2, bram_en3, pal_pending2, pal_pending3;
    logic hsync2, vsync2, vde2, hsync3, vsync3, vde3;
    logic [ADDR_W-1:0] bram_addr2, bram_addr3;
    logic [7:0] bram_data2, bram_data3;
    logic [23:0] rgb2, rgb3;

    logic [7:0] mem [32];
    logic [7:0] pipe2 [2];
    logic [7:0] pipe3 [3];

    logic [23:0] act_m [16];
    logic [23:0] sh_m [16];
    logic pend_m, eof_prev_m, exp_en;
    logic [ADDR_W-1:0] exp_addr;
    exp_t q2[$];
    exp_t q3[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // BRAM models: data for the registered address appears BRAM_LATENCY cycles later.
    always @(posedge clk) begin
        pipe2[0] <= mem[bram_addr2[4:0]];
        pipe2[1] <= pipe2[0];
        pipe3[0] <= mem[bram_addr3[4:0]];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign bram_data2 = pipe2[1];
    assign bram_data3 = pipe3[2];

    fbuf_pixel_fetch #(.BRAM_LATENCY(2), .ADDR_W(ADDR_W)) dut2 (
        .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .vde_in(vde_in),
        .eof_in(eof_in), .fbuf_address_in(fbuf_address_in), .test_pattern(test_pattern),
        .bram_en(bram_en2), .bram_addr(bram_addr2), .bram_data(bram_data2),
        .pal_wr_en(pal_wr_en), .pal_wr_addr(pal_wr_addr), .pal_wr_data(pal_wr_data),
        .pal_pending(pal_pending2), .rgb(rgb2), .hsync(hsync2), .vsync(vsync2), .vde(vde2)
    );

    fbuf_pixel_fetch #(.BRAM_LATENCY(3), .ADDR_W(ADDR_W)) dut3 (
        .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .vde_in(vde_in),
        .eof_in(eof_in), .fbuf_address_in(fbuf_address_in), .test_pattern(test_pattern),
        .bram_en(bram_en3), .bram_addr(bram_addr3), .bram_data(bram_data3),
        .pal_wr_en(pal_wr_en), .pal_wr_addr(pal_wr_addr), .pal_wr_data(pal_wr_data),
        .pal_pending(pal_pending3), .rgb(rgb3), .hsync(hsync3), .vsync(vsync3), .vde(vde3)
    );

    function automatic stim_t blank(input logic h, input logic v);
        stim_t s;
        s = '0;
        s.h = h;
        s.v = v;
        return s;
    endfunction

    function automatic stim_t pix(input int a);
        stim_t s;
        s = '0;
        s.de = 1'b1;
        s.addr = ADDR_W'(a);
        return s;
    endfunction

    function automatic stim_t tpix(input int a);
        stim_t s;
        s = pix(a);
        s.tp = 1'b1;
        return s;
    endfunction

    // Compare everything due this cycle, then the one-cycle BRAM request and pal_pending.
    task automatic checkOutput();
        exp_t e;
        while (q2.size() > 0 && q2[0].due == cyc) begin
            e = q2.pop_front();
            total++;
            assert ({hsync2, vsync2, vde2, rgb2} === e.val) else begin
                bad++;
                $error("[TB] FAIL pix_lat2 cyc=%0d got=%h exp=%h", cyc, {hsync2, vsync2, vde2, rgb2}, e.val);
            end
        end
        while (q3.size() > 0 && q3[0].due == cyc) begin
            e = q3.pop_front();
            total++;
            assert ({hsync3, vsync3, vde3, rgb3} === e.val) else begin
                bad++;
                $error("[TB] FAIL pix_lat3 cyc=%0d got=%h exp=%h", cyc, {hsync3, vsync3, vde3, rgb3}, e.val);
            end
        end
        total++;
        assert ({bram_en2, bram_addr2, bram_en3, bram_addr3} === {exp_en, exp_addr, exp_en, exp_addr}) else begin
            bad++;
            $error("[TB] FAIL bram_req cyc=%0d got=%b/%h %b/%h exp=%b/%h", cyc,
                   bram_en2, bram_addr2, bram_en3, bram_addr3, exp_en, exp_addr);
        end
        total++;
        assert ({pal_pending2, pal_pending3} === {pend_m, pend_m}) else begin
            bad++;
            $error("[TB] FAIL pal_pending cyc=%0d got=%b%b exp=%b", cyc, pal_pending2, pal_pending3, pend_m);
        end
    endtask

    // One pixel clock of stimulus; callers keep eof at least 5 blank cycles away from active pixels.
    task automatic applyStimulus(input stim_t s);
        logic [3:0]  idx;
        logic [23:0] px;
        @(negedge clk);
        cyc++;
        checkOutput();
        hsync_in = s.h;
        vsync_in = s.v;
        vde_in = s.de;
        eof_in = s.eof;
        test_pattern = s.tp;
        fbuf_address_in = s.addr;
        pal_wr_en = s.wr;
        pal_wr_addr = s.wa;
        pal_wr_data = s.wd;
        exp_addr = s.addr;
        exp_en = s.de & ~s.tp;
        idx = s.tp ? s.addr[3:0] : mem[s.addr[4:0]][7:4];
        px = s.de ? act_m[idx] : 24'h0;
        q2.push_back('{due: cyc + LAT2, val: {s.h, s.v, s.de, px}});
        q3.push_back('{due: cyc + LAT3, val: {s.h, s.v, s.de, px}});
        if (s.eof && !eof_prev_m && pend_m) begin
            for (int i = 0; i < 16; i++) act_m[i] = sh_m[i];
            pend_m = 1'b0;
        end
        if (s.wr) begin
            sh_m[s.wa] = s.wd;
            pend_m = 1'b1;
        end
        eof_prev_m = s.eof;
    endtask

    task automatic blanks(input int n);
        for (int k = 0; k < n; k++) applyStimulus(blank(1'b0, 1'b0));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic doReset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        {hsync_in, vsync_in, vde_in, eof_in, test_pattern, pal_wr_en} = '0;
        fbuf_address_in = '0;
        pal_wr_addr = '0;
        pal_wr_data = '0;
        #1;
        total++;
        assert ({rgb2, hsync2, vsync2, vde2, bram_en2, bram_addr2, pal_pending2} === '0) else begin
            bad++;
            $error("[TB] FAIL reset_lat2 got=%h exp=0", {rgb2, hsync2, vsync2, vde2, bram_en2, bram_addr2, pal_pending2});
        end
        total++;
        assert ({rgb3, hsync3, vsync3, vde3, bram_en3, bram_addr3, pal_pending3} === '0) else begin
            bad++;
            $error("[TB] FAIL reset_lat3 got=%h exp=0", {rgb3, hsync3, vsync3, vde3, bram_en3, bram_addr3, pal_pending3});
        end
        for (int i = 0; i < 16; i++) begin
            act_m[i] = {3{8'(i * 17)}};
            sh_m[i] = {3{8'(i * 17)}};
        end
        pend_m = 1'b0;
        eof_prev_m = 1'b0;
        exp_addr = '0;
        exp_en = 1'b0;
        q2.delete();
        q3.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 1; d <= LAT2; d++) q2.push_back('{due: cyc + d, val: 27'h0});
        for (int d = 1; d <= LAT3; d++) q3.push_back('{due: cyc + d, val: 27'h0});
    endtask

    initial begin
        stim_t s;
        $display("[TB] fbuf_pixel_fetch bench start");
        for (int i = 0; i < 32; i++) mem[i] = {4'((i * 7 + 3) % 16), 4'hA};
        mem[5] = 8'h30;
        mem[0] = 8'hF0;

        doReset();
        blanks(4);

        // Single pixel: address 5 holds index 3, so grey 333333 after the pipeline latency.
        applyStimulus(pix(5));
        blanks(5);
        for (int a = 1; a <= 20; a++) applyStimulus(pix(a));

        // Blanking with sync activity: BRAM returns F0 at address 0 but rgb must stay 0.
        for (int k = 0; k < 8; k++) applyStimulus(blank(k[0], k[1]));

        // Mid-frame palette write: active keeps the ramp until the eof rising edge.
        applyStimulus(pix(5));
        s = pix(3);
        s.wr = 1'b1;
        s.wa = 4'd3;
        s.wd = 24'hFF0000;
        applyStimulus(s);
        for (int a = 4; a <= 8; a++) applyStimulus(pix(a));
        applyStimulus(pix(5));
        blanks(5);
        s = blank(1'b0, 1'b1);
        s.eof = 1'b1;
        applyStimulus(s);
        blanks(4);
        for (int k = 0; k < 4; k++) applyStimulus(pix(5));
        blanks(2);

        // Write coinciding with the eof rising edge is deferred one frame.
        s = tpix(2);
        s.wr = 1'b1;
        s.wa = 4'd2;
        s.wd = 24'h0000FF;
        applyStimulus(s);
        blanks(5);
        s = blank(1'b0, 1'b1);
        s.eof = 1'b1;
        s.wr = 1'b1;
        s.wa = 4'd7;
        s.wd = 24'h00FF00;
        applyStimulus(s);
        blanks(4);
        applyStimulus(tpix(7));
        applyStimulus(tpix(2));
        applyStimulus(tpix(3));
        blanks(5);
        s = blank(1'b0, 1'b1);
        s.eof = 1'b1;
        applyStimulus(s);
        blanks(4);
        applyStimulus(tpix(7));
        applyStimulus(tpix(2));
        blanks(2);

        // Uncommitted write then a reset mid-line: the write is lost and the ramp returns.
        s = pix(9);
        s.wr = 1'b1;
        s.wa = 4'd9;
        s.wd = 24'h123456;
        applyStimulus(s);
        for (int a = 10; a < 14; a++) applyStimulus(pix(a));
        doReset();

        // Test pattern walks the full palette regardless of BRAM contents.
        for (int a = 0; a < 16; a++) applyStimulus(tpix(a));
        blanks(7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fbuf_pixel_fetch.md
# fbuf_pixel_fetch

Downstream stage of the video timing generator. Takes its sync/blank/eof strobes and framebuffer address, issues reads to the framebuffer BRAM, and expands each 8-bit stored pixel through a 16-entry, frame-synchronously updated 24-bit palette. Output is an RGB888 stream whose syncs are re-aligned to the pixel data, ready for the RGB-to-DVI encoder.

## Interface
- `BRAM_LATENCY`, default 2: cycles from `bram_addr`/`bram_en` to valid `bram_data`; legal range 1..4.
- `ADDR_W`, default 17: framebuffer address width.
- `clk` in 1: pixel clock.
- `rst` in 1: reset, asynchronous, active-high.
- `hsync_in`, `vsync_in`, `vde_in`, `eof_in` in 1 each: timing strobes from the timing generator.
- `fbuf_address_in` in `ADDR_W`: framebuffer address; 0 while `vde_in` low.
- `test_pattern` in 1: when 1, BRAM data is ignored and the palette index is `fbuf_address_in[3:0]`.
- `bram_en` out 1: BRAM read enable.
- `bram_addr` out `ADDR_W`: BRAM read address.
- `bram_data` in 8: BRAM read data. Bits [7:4] are the palette index; bits [3:0] are ignored.
- `pal_wr_en` in 1: palette shadow write strobe.
- `pal_wr_addr` in 4: palette entry.
- `pal_wr_data` in 24: {R,G,B}.
- `pal_pending` out 1: shadow holds uncommitted writes.
- `rgb` out 24: pixel {R[23:16],G[15:8],B[7:0]}.
- `hsync`, `vsync`, `vde` out 1 each: strobes aligned to `rgb`.

## Operation
- **Stage A (input register)**
  - `bram_addr` <= `fbuf_address_in`.
  - `bram_en` <= `vde_in & ~test_pattern`.
  - Strobes, `test_pattern` and `fbuf_address_in[3:0]` enter a delay line.
- **Stage B (BRAM wait)**
  - Delay line of depth `BRAM_LATENCY`.
  - When the delayed `test_pattern` bit is 1, the index is the delayed address nibble; otherwise it is `bram_data[7:4]`.
- **Stage C (output register)**
  - `rgb` <= `vde_d ? active[index] : 24'h0`.
  - Delayed strobes are registered to the outputs.
- **Palette**
  - Two banks of 16x24 registers: shadow and active.
  - `pal_wr_en` writes the shadow bank only and sets `pal_pending`.
  - Commit event: rising edge of `eof_in`, detected against the previous-cycle `eof_in`.
  - On commit with `pal_pending`=1: all 16 shadow entries are copied into active in one cycle, and `pal_pending` is cleared.
  - Commit with `pal_pending`=0: no effect.
- **Simultaneous write and commit:** the commit copies the pre-write shadow contents. The write lands in shadow. `pal_pending` stays 1, so the entry is applied at the next frame's commit.
- **Reset values**
  - Both banks: entry i = {3{i*17}} (greyscale ramp, 8'h00..8'hFF).
  - `pal_pending`=0, all delay-line stages 0.
  - `rgb`=0, `hsync`=`vsync`=`vde`=0, `bram_en`=0, `bram_addr`=0.
- **Reset mid-frame:** the pipeline flushes to 0 and palette writes not yet committed are lost. After `rst` is released, the output resumes exactly `LATENCY` cycles after the inputs resume.
- **Blanking:** `rgb` is forced to 0 whenever the aligned `vde` is 0, regardless of BRAM contents.

## Timing
- `LATENCY` = `BRAM_LATENCY` + 2; default 4.
- Inputs sampled at edge n:
  - `bram_addr`/`bram_en` valid after edge n+1.
  - `bram_data` consumed at edge n+1+`BRAM_LATENCY`.
  - `rgb` and strobes valid after edge n+2+`BRAM_LATENCY`.
- All outputs are registered; there is no combinational input-to-output path.
- The palette is never modified while `eof` is low, so a visible frame always uses a single palette.
- Throughput is one pixel per clock, with no stalls and no back-pressure.

## Structure
- Shared video package:
  - `RGB_W`=24, `PAL_ENTRIES`=16, `PAL_IDX_W`=4.
  - Default greyscale ramp function.
  - `rgb_t` typedef.
- Natural sub-module: `fbuf_palette`, holding the shadow/active banks, the commit logic and `pal_pending`, with a combinational read port.
- The top level holds the delay lines and stage registers.

## Test plan
- **Reset:** assert `rst` asynchronously mid-line -> all outputs 0 immediately. Palette reads 000000, 111111 ... FFFFFF for indices 0..15.
- **Latency:** `vde_in`=1, `fbuf_address_in`=5, BRAM model with `bram_data`=8'h30 -> `bram_addr`=5 one cycle later; `rgb`=24'h333333 with `vde`=1 exactly 4 cycles after input. Repeat with `BRAM_LATENCY`=3 -> 5 cycles.
- **Blanking:** `vde_in`=0 with BRAM returning 8'hF0 -> `rgb`=0 and `bram_en`=0; `hsync`/`vsync` still track inputs delayed by 4.
- **Frame-synchronous commit:** write entry 3 = 24'hFF0000 mid-frame -> `pal_pending`=1, and index-3 pixels stay 333333 until the `eof_in` rising edge; the next frame shows FF0000 and `pal_pending`=0.
- **Simultaneous write and commit:** `pal_wr_en` on the `eof_in` rising-edge cycle (entry 7 = 00FF00) -> active entry 7 unchanged and `pal_pending`=1; applied at the following `eof_in` rise.
- **Test pattern:** `test_pattern`=1, addresses 0..15 -> `bram_en`=0, `rgb` steps through the greyscale ramp, and `bram_data` is ignored.
